aes_key_expand: RTL and testbench
=================================

AES_KEY_EXPAND -- requirements
Module: aes_key_expand

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: key_in  input  128  AES-128 cipher key; word w0 = key_in[127:96], w3 = key_in[31:0].
REQ-004 SHALL have port: key_valid  input  1  key_in valid this cycle.
REQ-005 SHALL have port: key_ready  output  1  block accepts a key this cycle.
REQ-006 SHALL have port: busy  output  1  expansion in progress.
REQ-007 SHALL have port: done  output  1  all 11 round keys valid; level signal.
REQ-008 SHALL have port: rk_idx  input  4  round-key read index, 0..10.
REQ-009 SHALL have port: rk_out  output  128  round key selected by rk_idx, same word ordering as key_in.
REQ-010 SHALL have parameter: none; AES-128 only (Nk=4, Nr=10).

Function
REQ-011 SHALL implement FSM states IDLE, EXPAND, DONE.
REQ-012 key_ready SHALL be 1 in IDLE and DONE, 0 in EXPAND; busy SHALL be 1 only in EXPAND; done SHALL be 1 only in DONE.
REQ-013 Handshake: key accepted at a rising edge where key_valid && key_ready; rk[0] <= key_in, round counter <= 1, state -> EXPAND.
REQ-014 In EXPAND, each cycle SHALL write rk[r] from rk[r-1] per FIPS-197: t = SubWord(RotWord(w3)) ^ {Rcon[r],24'h0}; w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
REQ-015 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1b,36.
REQ-016 After rk[10] is written, state SHALL go EXPAND -> DONE on that same edge; round counter then stops.
REQ-017 Latency: key accepted at edge N; rk[r] valid after edge N+r; done=1 after edge N+10 (10 cycles in EXPAND).
REQ-018 key_valid during EXPAND SHALL be ignored; no queuing; rk storage and counter unaffected.
REQ-019 Key accepted in DONE SHALL restart: done falls and busy rises after that edge; rk[0] overwritten with new key.
REQ-020 rk_out SHALL be combinational read of rk[rk_idx]; rk_idx 11..15 SHALL return 128'h0.
REQ-021 Reading an entry not yet rewritten during EXPAND SHALL return its previous contents (no bypass); consumers gate on done.
REQ-022 Round-key storage SHALL be 11x128 flops; no memory macro.

Reset
REQ-023 rst asserted SHALL asynchronously force: state IDLE, round counter 0, all rk[] 0, key_ready 1, busy 0, done 0.
REQ-024 rst mid-EXPAND SHALL abort expansion; no partial done; next key after release starts fresh.
REQ-025 First key accept possible on first rising edge after rst deasserts.

Structure
REQ-026 Shared package aes_pkg SHALL hold: round-key type (128-bit), word type (32-bit), NR=10 constant, Rcon table, FSM state enum.
REQ-027 SHALL instantiate 4 copies of sub-module aes_sbox (8-bit in, 8-bit out, combinational FIPS-197 S-box LUT) for SubWord; aes_sbox reused by encry.
REQ-028 Block sits upstream of encry, supplying round keys; encry's input_key equals rk[0].

Verification
REQ-029 Key 000102030405060708090a0b0c0d0e0f -> rk[1]=d6aa74fdd2af72fadaa678f1d6ab76fe, rk[10]=13111d7fe3944a17f307a78b4d2b30c5, done exactly 10 cycles after accept.
REQ-030 Key 2b7e151628aed2a6abf7158809cf4f3c -> rk[1]=a0fafe1788542cb123a339392a6c7605, rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-031 key_valid held high with changed key_in during EXPAND -> key_ready=0, second key ignored, REQ-029 results unchanged.
REQ-032 rst asserted at cycle 5 of EXPAND -> outputs immediately reset (all rk=0, done=0, busy=0); re-issue key -> correct REQ-029 results.
REQ-033 In DONE apply second key (REQ-030 key) -> done drops next cycle, rk_idx=0 reads 2b7e...4f3c, REQ-030 results after 10 cycles; rk_idx=12 -> rk_out=0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 types and constants for the key schedule and the cipher core.
package aes_pkg;

    typedef logic [127:0] rk_t;
    typedef logic [31:0]  word_t;

    localparam int NR = 10;

    localparam logic [7:0] RCON [1:NR] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Round constant lookup; rounds outside 1..NR yield zero.
    function automatic logic [7:0] rcon_f(input logic [3:0] r);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 1; i <= NR; i++) begin
            if (r == 4'(i)) v = RCON[i];
        end
        return v;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// FIPS-197 forward S-box as a combinational lookup table.
module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign s_o = SBOX[a_i];

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: one round key per cycle into an 11-entry flop bank.
// Handshake: a key is taken on a rising edge where key_valid && key_ready; no backpressure beyond key_ready.
module aes_key_expand
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         busy,
    output logic         done,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_out,
    output state_e       dbg_state
);

    state_e     state_q, state_d;
    logic [3:0] rnd_q, rnd_d;
    rk_t        rk_q [0:NR];
    rk_t        rk_d [0:NR];

    rk_t   prev_rk, next_rk;
    word_t w0, w1, w2, w3, rot_w, sub_w, t_w;
    word_t n0, n1, n2, n3;

    always_comb begin
        prev_rk = '0;
        for (int i = 0; i < NR; i++) begin
            if (rnd_q == 4'(i + 1)) prev_rk = rk_q[i];
        end
    end

    assign {w0, w1, w2, w3} = prev_rk;
    assign rot_w = {w3[23:0], w3[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sub
        aes_sbox u_sbox (
            .a_i (rot_w[8*b +: 8]),
            .s_o (sub_w[8*b +: 8])
        );
    end

    assign t_w     = sub_w ^ {rcon_f(rnd_q), 24'h000000};
    assign n0      = w0 ^ t_w;
    assign n1      = w1 ^ n0;
    assign n2      = w2 ^ n1;
    assign n3      = w3 ^ n2;
    assign next_rk = {n0, n1, n2, n3};

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        rk_d    = rk_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (key_valid) begin
                    rk_d[0] = key_in;
                    rnd_d   = 4'd1;
                    state_d = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                for (int i = 1; i <= NR; i++) begin
                    if (rnd_q == 4'(i)) rk_d[i] = next_rk;
                end
                // Counter parks at NR once the last round key lands.
                if (rnd_q == 4'(NR)) state_d = ST_DONE;
                else                 rnd_d   = rnd_q + 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rnd_q   <= 4'd0;
            for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            for (int i = 0; i <= NR; i++) rk_q[i] <= rk_d[i];
        end
    end

    always_comb begin
        rk_out = '0;
        for (int i = 0; i <= NR; i++) begin
            if (rk_idx == 4'(i)) rk_out = rk_q[i];
        end
    end

    assign key_ready = (state_q != ST_EXPAND);
    assign busy      = (state_q == ST_EXPAND);
    assign done      = (state_q == ST_DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: FIPS-197 vectors, restart from DONE, ignored keys and mid-run reset.
module tb_aes_key_expand;
    import aes_pkg::*;

    logic         clk;
    logic         rst;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         done;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;
    state_e       dbg_state;

    aes_key_expand dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .busy      (busy),
        .done      (done),
        .rk_idx    (rk_idx),
        .rk_out    (rk_out),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] key;
        logic [127:0] rk1;
        logic [127:0] rk10;
    } vec_t;

    vec_t         vecs [2];
    logic [127:0] exp_q [$];
    int           n_vec;
    int           n_err;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic read_rk(input logic [3:0] idx, output logic [127:0] val);
        rk_idx = idx;
        #1;
        val = rk_out;
    endtask

    // Entered at edge+1ns; returns at a point after done has been observed.
    task automatic apply_key(input vec_t v, input bit hold_alt, input logic [127:0] alt_key,
                             input logic [127:0] prev_rk10);
        logic [127:0] val;
        int           cnt;
        key_in    = v.key;
        key_valid = 1'b1;
        exp_q.push_back(v.key);
        exp_q.push_back(v.rk1);
        exp_q.push_back(v.rk10);
        @(posedge clk);
        #1;
        check("busy_after_accept", 128'(busy), 128'(1'b1));
        check("done_after_accept", 128'(done), 128'(1'b0));
        check("ready_after_accept", 128'(key_ready), 128'(1'b0));
        if (hold_alt) key_in = alt_key;
        else          key_valid = 1'b0;
        read_rk(4'd0, val);
        check("rk0_new_key", val, v.key);
        read_rk(4'd10, val);
        check("rk10_no_bypass", val, prev_rk10);
        cnt = 0;
        while (!done && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
            if (hold_alt && !done) check("ready_during_expand", 128'(key_ready), 128'(1'b0));
        end
        key_valid = 1'b0;
        check("done_latency", 128'(cnt), 128'(10));
        read_rk(4'd0, val);
        check("rk0", val, exp_q.pop_front());
        read_rk(4'd1, val);
        check("rk1", val, exp_q.pop_front());
        read_rk(4'd10, val);
        check("rk10", val, exp_q.pop_front());
    endtask

    initial begin
        logic [127:0] val;
        n_vec = 0;
        n_err = 0;
        vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f,
                    128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
                    128'h13111d7fe3944a17f307a78b4d2b30c5};
        vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'ha0fafe1788542cb123a339392a6c7605,
                    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

        rst       = 1'b1;
        key_in    = '0;
        key_valid = 1'b0;
        rk_idx    = 4'd0;
        #12;
        check("rst_ready", 128'(key_ready), 128'(1'b1));
        check("rst_busy", 128'(busy), 128'(1'b0));
        check("rst_done", 128'(done), 128'(1'b0));
        read_rk(4'd0, val);
        check("rst_rk0", val, '0);
        read_rk(4'd10, val);
        check("rst_rk10", val, '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table: first key from IDLE, second key restarts from DONE.
        for (int i = 0; i < 2; i++) begin
            apply_key(vecs[i], 1'b0, '0, (i == 0) ? 128'h0 : vecs[0].rk10);
        end
        check("done_level_held", 128'(done), 128'(1'b1));
        for (int idx = 11; idx <= 15; idx++) begin
            read_rk(4'(idx), val);
            check("rk_idx_out_of_range", val, '0);
        end

        // Different key held valid through the whole expansion must be ignored.
        apply_key(vecs[0], 1'b1, vecs[1].key, vecs[1].rk10);

        // Reset at cycle 5 of an expansion, then rerun from scratch.
        key_in    = vecs[1].key;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", 128'(busy), 128'(1'b0));
        check("midrst_done", 128'(done), 128'(1'b0));
        check("midrst_ready", 128'(key_ready), 128'(1'b1));
        for (int idx = 0; idx <= 10; idx += 5) begin
            read_rk(4'(idx), val);
            check("midrst_rk", val, '0);
        end
        read_rk(4'd1, val);
        check("midrst_rk1", val, '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        apply_key(vecs[0], 1'b0, '0, 128'h0);

        check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
